// File: rtl/inst_queue_if.sv
// Fetch/dispatch side of the instruction queue: push port, head port and the
// flow-control flags the queue needs to decide when the head is consumed.
interface iq_if;
  logic        rdy;
  logic        clear;
  logic        push_valid;
  logic [31:0] push_inst;
  logic [31:0] push_pc;
  logic [5:0]  push_optype;
  logic        push_pred_taken;
  logic        iq_full;
  logic        ROB_full;
  logic        RS_full;
  logic        LSB_full;
  logic        ifetch_valid;
  logic [5:0]  ifetch_optype;
  logic [31:0] ifetch_inst;
  logic [31:0] ifetch_pc;
  logic        ifetch_pred_taken;
  logic        pop;

  modport slave (
    input  rdy, clear, push_valid, push_inst, push_pc, push_optype, push_pred_taken,
    input  ROB_full, RS_full, LSB_full,
    output iq_full, ifetch_valid, ifetch_optype, ifetch_inst, ifetch_pc,
    output ifetch_pred_taken, pop
  );

  modport master (
    output rdy, clear, push_valid, push_inst, push_pc, push_optype, push_pred_taken,
    output ROB_full, RS_full, LSB_full,
    input  iq_full, ifetch_valid, ifetch_optype, ifetch_inst, ifetch_pc,
    input  ifetch_pred_taken, pop
  );
endinterface

// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetcher and dispatcher; the head is popped
// in the same cycle its target units (ROB plus RS or LSB) can accept it.
module inst_queue #(
  parameter int          IQ_ADDR_W = 4,
  parameter logic [5:0]  OP_LB     = 6'd11,
  parameter logic [5:0]  OP_SW     = 6'd18
) (
  input  logic clk,
  input  logic rst,
  iq_if.slave  bus
);
  localparam int                 DEPTH    = 1 << IQ_ADDR_W;
  localparam logic [IQ_ADDR_W:0] FULL_CNT = (IQ_ADDR_W + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [5:0]  optype;
    logic        pred_taken;
  } entry_t;

  entry_t               r_mem [DEPTH];
  logic [IQ_ADDR_W-1:0] r_head;
  logic [IQ_ADDR_W-1:0] r_tail;
  logic [IQ_ADDR_W:0]   r_count;

  entry_t w_head_entry;
  entry_t w_push_entry;
  logic   w_valid;
  logic   w_is_ls;
  logic   w_pop;
  logic   w_push;

  always_comb begin
    w_valid      = (r_count != '0);
    w_head_entry = w_valid ? r_mem[r_head] : '0;
    w_is_ls      = (w_head_entry.optype >= OP_LB) && (w_head_entry.optype <= OP_SW);
    w_pop        = bus.rdy && !bus.clear && w_valid && !bus.ROB_full &&
                   (w_is_ls ? !bus.LSB_full : !bus.RS_full);
    // A push while full is dropped even if the head pops this same cycle.
    w_push       = bus.rdy && !bus.clear && bus.push_valid && (r_count != FULL_CNT);
    w_push_entry = '{inst: bus.push_inst, pc: bus.push_pc,
                     optype: bus.push_optype, pred_taken: bus.push_pred_taken};
  end

  assign bus.iq_full           = (r_count == FULL_CNT);
  assign bus.ifetch_valid      = w_valid;
  assign bus.ifetch_optype     = w_head_entry.optype;
  assign bus.ifetch_inst       = w_head_entry.inst;
  assign bus.ifetch_pc         = w_head_entry.pc;
  assign bus.ifetch_pred_taken = w_head_entry.pred_taken;
  assign bus.pop               = w_pop;

  // NOTE: storage has no reset; validity is carried by r_count alone, so
  // resetting the array would only add a reset tree for no functional gain.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_push_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.rdy) begin
      if (bus.clear) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + 1'b1;
        if (w_pop)  r_head <= r_head + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: stimulus pushes expected entries into a
// scoreboard, an independent monitor compares every popped head against it.
module tb_inst_queue;
  localparam logic [5:0] OP_BGEU = 6'd10;
  localparam logic [5:0] OP_LB   = 6'd11;
  localparam logic [5:0] OP_LW   = 6'd13;
  localparam logic [5:0] OP_SW   = 6'd18;
  localparam logic [5:0] OP_ADDI = 6'd19;
  localparam logic [5:0] OP_ADD  = 6'd28;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [5:0]  optype;
    logic        pred_taken;
  } entry_t;

  typedef struct packed {
    logic [5:0] op;
    logic       rs_full;
    logic       lsb_full;
    logic       exp_pop;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  iq_if bus ();

  inst_queue dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  entry_t sb[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     n_pops   = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one push for a single cycle; accepted pushes become expected pops.
  task automatic push(input logic [31:0] pc, input logic [5:0] op, input bit accept);
    entry_t e;
    e = '{inst: ~pc, pc: pc, optype: op, pred_taken: pc[2]};
    bus.push_valid      = 1'b1;
    bus.push_pc         = e.pc;
    bus.push_inst       = e.inst;
    bus.push_optype     = e.optype;
    bus.push_pred_taken = e.pred_taken;
    if (accept) sb.push_back(e);
    step();
    bus.push_valid = 1'b0;
  endtask

  task automatic wait_empty(input int limit);
    for (int i = 0; i < limit && bus.ifetch_valid; i++) step();
    check("drain_empty", bus.ifetch_valid, 1'b0);
  endtask

  // Monitor: every cycle the DUT pops, the head must match the oldest expectation.
  initial begin
    entry_t exp_e;
    forever begin
      @(negedge clk);
      if (!rst && bus.pop) begin
        n_pops++;
        if (sb.size() == 0) begin
          check("pop_unexpected", {bus.ifetch_inst, bus.ifetch_pc}, 72'h0);
        end else begin
          exp_e = sb.pop_front();
          check("pop_entry", {bus.ifetch_inst, bus.ifetch_pc, bus.ifetch_optype,
                              bus.ifetch_pred_taken}, exp_e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [8];
    int   p0;
    vecs = '{'{OP_LW,   1'b0, 1'b1, 1'b0}, '{OP_LW,   1'b1, 1'b0, 1'b1},
             '{OP_ADD,  1'b1, 1'b0, 1'b0}, '{OP_ADD,  1'b0, 1'b1, 1'b1},
             '{OP_LB,   1'b1, 1'b0, 1'b1}, '{OP_SW,   1'b1, 1'b0, 1'b1},
             '{OP_ADDI, 1'b0, 1'b1, 1'b1}, '{OP_BGEU, 1'b0, 1'b1, 1'b1}};

    rst = 1'b1;
    bus.rdy = 1'b1; bus.clear = 1'b0; bus.push_valid = 1'b0;
    bus.push_inst = '0; bus.push_pc = '0; bus.push_optype = '0; bus.push_pred_taken = 1'b0;
    bus.ROB_full = 1'b0; bus.RS_full = 1'b0; bus.LSB_full = 1'b0;
    #2;
    check("reset_valid", bus.ifetch_valid, 1'b0);
    check("reset_full",  bus.iq_full, 1'b0);
    check("reset_pop",   bus.pop, 1'b0);
    check("reset_pc",    bus.ifetch_pc, 32'h0);
    step();
    rst = 1'b0;

    // Three ADDs, popped in order; no bypass from the empty queue.
    p0 = n_pops;
    bus.push_valid = 1'b1; bus.push_pc = 32'h0; bus.push_inst = ~32'h0;
    bus.push_optype = OP_ADD; bus.push_pred_taken = 1'b0;
    sb.push_back('{inst: ~32'h0, pc: 32'h0, optype: OP_ADD, pred_taken: 1'b0});
    @(negedge clk);
    check("no_bypass", bus.ifetch_valid, 1'b0);
    step();
    bus.push_valid = 1'b0;
    check("valid_after_push", bus.ifetch_valid, 1'b1);
    check("head_pc_first", bus.ifetch_pc, 32'h0);
    push(32'h4, OP_ADD, 1'b1);
    push(32'h8, OP_ADD, 1'b1);
    wait_empty(10);
    check("pops_3", n_pops - p0, 3);

    // Fill to 16 with ROB full, drop a 17th, then full+push+pop is pop-only.
    p0 = n_pops;
    bus.ROB_full = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push(32'h100 + 32'(4 * i), OP_ADD, 1'b1);
      if (i == 14) check("not_full_15", bus.iq_full, 1'b0);
    end
    check("full_16", bus.iq_full, 1'b1);
    push(32'hDEAD0000, OP_ADD, 1'b0);
    check("full_after_drop", bus.iq_full, 1'b1);
    check("head_after_drop", bus.ifetch_pc, 32'h100);
    bus.ROB_full = 1'b0;
    push(32'hBAD00000, OP_ADD, 1'b0);
    check("full_pop_push_15", bus.iq_full, 1'b0);
    wait_empty(40);
    check("pops_16", n_pops - p0, 16);

    // Unit-full steering: load/store heads wait on LSB, others on RS.
    for (int k = 0; k < 8; k++) begin
      bus.ROB_full = 1'b1; bus.RS_full = 1'b0; bus.LSB_full = 1'b0;
      push(32'h300 + 32'(4 * k), vecs[k].op, 1'b1);
      bus.RS_full = vecs[k].rs_full; bus.LSB_full = vecs[k].lsb_full; bus.ROB_full = 1'b0;
      @(negedge clk);
      check("steer_pop", bus.pop, vecs[k].exp_pop);
      check("steer_head", bus.ifetch_pc, 32'h300 + 32'(4 * k));
      step();
      if (!vecs[k].exp_pop) begin
        @(negedge clk);
        check("steer_hold", {bus.pop, bus.ifetch_valid}, 2'b01);
        step();
        bus.RS_full = 1'b0; bus.LSB_full = 1'b0;
        step();
      end
      check("steer_empty", bus.ifetch_valid, 1'b0);
    end

    // Clear with 10 entries and a concurrent push.
    bus.ROB_full = 1'b1;
    for (int i = 0; i < 10; i++) push(32'h400 + 32'(4 * i), OP_ADD, 1'b1);
    check("pre_clear_head", bus.ifetch_pc, 32'h400);
    bus.ROB_full = 1'b0; bus.clear = 1'b1;
    bus.push_valid = 1'b1; bus.push_pc = 32'hC1EA0000;
    @(negedge clk);
    check("pop_during_clear", bus.pop, 1'b0);
    step();
    bus.clear = 1'b0; bus.push_valid = 1'b0;
    sb.delete();
    check("clear_valid", bus.ifetch_valid, 1'b0);
    check("clear_full", bus.iq_full, 1'b0);
    check("clear_pc", bus.ifetch_pc, 32'h0);
    step(); step();
    check("clear_push_dropped", bus.ifetch_valid, 1'b0);

    // 40-entry stream with continuous pops: pointers wrap twice, count stays 1.
    p0 = n_pops;
    for (int i = 0; i < 40; i++) begin
      push(32'h1000 + 32'(4 * i), OP_ADD, 1'b1);
      check("stream_head", {bus.ifetch_valid, bus.iq_full, bus.ifetch_pc},
            {2'b10, 32'h1000 + 32'(4 * i)});
    end
    step();
    check("stream_empty", bus.ifetch_valid, 1'b0);
    check("pops_40", n_pops - p0, 40);

    // rdy low freezes everything for 5 cycles.
    p0 = n_pops;
    bus.ROB_full = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h2000 + 32'(4 * i), OP_ADD, 1'b1);
    bus.ROB_full = 1'b0; bus.rdy = 1'b0;
    bus.push_valid = 1'b1; bus.push_pc = 32'hEEEE0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rdy_low_hold", {bus.pop, bus.ifetch_pc}, {1'b0, 32'h2000});
      step();
    end
    bus.rdy = 1'b1; bus.push_valid = 1'b0;
    wait_empty(10);
    check("pops_after_rdy", n_pops - p0, 4);

    // Asynchronous reset mid-cycle at count 4.
    bus.ROB_full = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h3000 + 32'(4 * i), OP_ADD, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outputs", {bus.ifetch_valid, bus.iq_full, bus.pop, bus.ifetch_pc},
          35'h0);
    sb.delete();
    step();
    rst = 1'b0; bus.ROB_full = 1'b0;
    p0 = n_pops;
    push(32'h4000, OP_ADD, 1'b1);
    wait_empty(10);
    check("pops_after_rst", n_pops - p0, 1);
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the instruction fetcher and the dispatcher. It buffers fetched, pre-decoded instructions in a circular FIFO and presents the oldest one to the dispatcher as `ifetch_valid`/`ifetch_optype` plus its payload. It pops an entry in exactly the cycle the dispatcher's target units can accept it. It decouples fetch stalls from issue stalls and empties in one cycle on a ROB-driven flush.

## Interface
- `IQ_ADDR_W`, default 4: pointer width; depth = 2^`IQ_ADDR_W` (16 entries).
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `rdy` input, 1 bit: global ready; when low, all state holds.
- `clear` input, 1 bit: flush from ROB (mispredict/exception).
- `push_valid` input, 1 bit: fetcher presents an instruction.
- `push_inst` input, 32 bits: raw instruction word.
- `push_pc` input, 32 bits: instruction PC.
- `push_optype` input, 6 bits: decoded op type, encoded per `defines.v`.
- `push_pred_taken` input, 1 bit: branch prediction bit.
- `iq_full` output, 1 bit: to fetcher; high when count == depth.
- `ROB_full` input, 1 bit.
- `RS_full` input, 1 bit.
- `LSB_full` input, 1 bit.
- `ifetch_valid` output, 1 bit: head entry valid (count != 0).
- `ifetch_optype` output, 6 bits: head optype.
- `ifetch_inst` output, 32 bits: head instruction word.
- `ifetch_pc` output, 32 bits: head PC.
- `ifetch_pred_taken` output, 1 bit: head prediction bit.
- `pop` output, 1 bit: head consumed this cycle.

## Operation
- Storage: circular array of depth 2^`IQ_ADDR_W`; each entry holds {inst, pc, optype, pred_taken}.
- State: `head`, `tail` (`IQ_ADDR_W` bits, wrap modulo depth); `count` (`IQ_ADDR_W`+1 bits, range 0..depth).
- Head outputs are combinational reads at `head`. When `count`==0, all `ifetch_*` outputs read 0.
- Load/store classification: `is_ls` = (`ifetch_optype` >= `LB` && `ifetch_optype` <= `SW`).
- Pop condition: `pop` = `rdy` && ~`clear` && `ifetch_valid` && ~`ROB_full` && (`is_ls` ? ~`LSB_full` : ~`RS_full`).
- Push condition: `do_push` = `rdy` && ~`clear` && `push_valid` && (`count` != depth).
- A push while full is dropped, even if a pop happens in the same cycle. The fetcher must gate on `iq_full`.
- On push: write the entry at `tail`; `tail`+1.
- On pop: `head`+1.
- `count` update: +1 on push only; −1 on pop only; unchanged when both or neither occur.
- Clear (with `rdy` high): `head`=`tail`=0 and `count`=0 next cycle. It dominates any same-cycle push or pop; `pop` is 0 during the clear cycle.
- `rdy` low: no push, no pop, no clear; all registers hold and `pop`=0.
- Entry contents are not reset; only pointers and count are.

## Timing
- Reset (asynchronous): `head`=`tail`=`count`=0. Consequently `iq_full`=0, `ifetch_valid`=0, `ifetch_*`=0, `pop`=0 immediately, with no clock needed.
- Push-to-visible latency: an entry pushed in cycle N appears at the head in cycle N+1 at the earliest. There is no bypass from an empty queue.
- Pop is same-cycle: the dispatcher issues the head in cycle N, and the next entry is presented in cycle N+1.
- Throughput: 1 push and 1 pop per cycle sustained when 0 < `count` < depth.
- `iq_full` is registered-state derived (`count` == depth) and changes only on clock edges.
- Boundary conditions:
  - Empty plus simultaneous push and pop: pop cannot occur because `ifetch_valid`=0, so the result is count 1.
  - Full plus simultaneous pop and push: pop only, so the result is count depth−1.
  - `head` wraps from 15 to 0 and `tail` wraps from 15 to 0 without disturbing `count`.
- Reset asserted mid-operation clears pointers immediately. Entries are lost and the outputs go to the reset values above.

## Test plan
- Reset, then push 3 entries (pc 0x0, 0x4, 0x8, optype ADD) with RS/ROB not full -> `ifetch_valid` rises the cycle after the first push; pops occur in order 0x0, 0x4, 0x8; `count` returns to 0.
- Push 16 entries with `ROB_full`=1 -> `iq_full`=1 after the 16th push; a 17th push is dropped. Deassert `ROB_full` -> 16 pops in order; no 17th entry appears.
- Head is LW with `LSB_full`=1 and `RS_full`=0 -> `pop`=0 and the head is held. Deassert `LSB_full` -> pop the next cycle. Repeat with an ADD head and `RS_full`=1 -> held.
- Fill to 10 entries, assert `clear` with `push_valid`=1 -> next cycle `count`=0, `ifetch_valid`=0, and the pushed entry is not stored.
- Stream 40 pushes with continuous pops -> pointers wrap twice; the output PC sequence matches the input sequence exactly; `count` stays at 1.
- Hold `rdy`=0 for 5 cycles with `push_valid`=1 and pop conditions true -> no state change and `pop`=0; at `count`=4, assert `rst` asynchronously mid-cycle -> `ifetch_valid`=0 immediately.
